// File: rtl/commit_trace_buffer.sv
// Commit-trace capture unit: records retired instructions into a FIFO drained over valid/ready.
// Optional per-record cycle stamp enabled by defining TRACE_CYCLE_STAMP_EN.
module commit_trace_buffer #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_trig_en,
    input  logic [PC_W-1:0]   cfg_trig_pc,
    input  logic [CNT_W-1:0]  cfg_limit,
    input  logic              cmt_valid,
    input  logic [PC_W-1:0]   cmt_pc,
    input  logic [PC_W-1:0]   cmt_inst,
    input  logic              cmt_wb_en,
    input  logic [REG_AW-1:0] cmt_wb_addr,
    input  logic [PC_W-1:0]   cmt_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_inst,
    output logic              out_wb_en,
    output logic [REG_AW-1:0] out_wb_addr,
    output logic [PC_W-1:0]   out_wb_data,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  overflow_cnt,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [31:0]       out_cycle,
`endif
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_limit;
    logic               r_trig_en;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_ovf;
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;

    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [PC_W-1:0]    r_mem_inst  [DEPTH];
    logic               r_mem_wb_en [DEPTH];
    logic [REG_AW-1:0]  r_mem_wb_a  [DEPTH];
    logic [PC_W-1:0]    r_mem_wb_d  [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_cap_evt;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [AW-1:0]      w_wr_idx;
    logic [AW-1:0]      w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

    // A commit coinciding with cfg_start belongs to neither the old nor the new session.
    assign w_cap_evt = cmt_valid && !cfg_start &&
                       ((r_state == S_CAPTURE) ||
                        (r_state == S_ARMED && r_trig_en && cmt_pc == cfg_trig_pc));

    // full is taken before this cycle's pop, so a push at full is dropped even while popping.
    assign w_push    = w_cap_evt && !w_full;
    assign w_pop     = !w_empty && out_ready;
    assign w_cnt_inc = (r_count == '1) ? r_count : r_count + CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        if (cfg_start) begin
            w_state_nxt = cfg_trig_en ? S_ARMED : S_CAPTURE;
        end else begin
            case (r_state)
                S_ARMED, S_CAPTURE: begin
                    if (w_cap_evt) begin
                        if (r_limit != '0 && w_cnt_inc == r_limit) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_CAPTURE;
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_limit   <= '0;
            r_trig_en <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (cfg_start) begin
                r_limit   <= cfg_limit;
                r_trig_en <= cfg_trig_en;
                r_count   <= '0;
            end else if (w_cap_evt) begin
                r_count <= w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_ovf <= '0;
        end else if (w_cap_evt && w_full && r_ovf != '1) begin
            r_ovf <= r_ovf + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_pc[w_wr_idx]    <= cmt_pc;
            r_mem_inst[w_wr_idx]  <= cmt_inst;
            r_mem_wb_en[w_wr_idx] <= cmt_wb_en;
            r_mem_wb_a[w_wr_idx]  <= cmt_wb_addr;
            r_mem_wb_d[w_wr_idx]  <= cmt_wb_data;
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_mem_cyc [DEPTH];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_cyc[w_wr_idx] <= r_cycle;
        end
    end

    assign out_cycle = r_mem_cyc[w_rd_idx];
`endif

    assign out_valid    = !w_empty;
    assign out_pc       = r_mem_pc[w_rd_idx];
    assign out_inst     = r_mem_inst[w_rd_idx];
    assign out_wb_en    = r_mem_wb_en[w_rd_idx];
    assign out_wb_addr  = r_mem_wb_a[w_rd_idx];
    assign out_wb_data  = r_mem_wb_d[w_rd_idx];
    assign state_o      = r_state;
    assign count_o      = r_count;
    assign overflow_cnt = r_ovf;
    assign full         = w_full;
    assign empty        = w_empty;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: vector table plus hand sequences for overflow, streaming and reset.
// Stamp checks are included when TRACE_CYCLE_STAMP_EN is defined.
module tb_commit_trace_buffer;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 16;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              cfg_start;
    logic              cfg_trig_en;
    logic [PC_W-1:0]   cfg_trig_pc;
    logic [CNT_W-1:0]  cfg_limit;
    logic              cmt_valid;
    logic [PC_W-1:0]   cmt_pc;
    logic [PC_W-1:0]   cmt_inst;
    logic              cmt_wb_en;
    logic [REG_AW-1:0] cmt_wb_addr;
    logic [PC_W-1:0]   cmt_wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_inst;
    logic              out_wb_en;
    logic [REG_AW-1:0] out_wb_addr;
    logic [PC_W-1:0]   out_wb_data;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  count_o;
    logic [CNT_W-1:0]  overflow_cnt;
    logic              full;
    logic              empty;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]       out_cycle;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    commit_trace_buffer #(
        .PC_W   (PC_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_trig_en  (cfg_trig_en),
        .cfg_trig_pc  (cfg_trig_pc),
        .cfg_limit    (cfg_limit),
        .cmt_valid    (cmt_valid),
        .cmt_pc       (cmt_pc),
        .cmt_inst     (cmt_inst),
        .cmt_wb_en    (cmt_wb_en),
        .cmt_wb_addr  (cmt_wb_addr),
        .cmt_wb_data  (cmt_wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_wb_en    (out_wb_en),
        .out_wb_addr  (out_wb_addr),
        .out_wb_data  (out_wb_data),
        .state_o      (state_o),
        .count_o      (count_o),
        .overflow_cnt (overflow_cnt),
`ifdef TRACE_CYCLE_STAMP_EN
        .out_cycle    (out_cycle),
`endif
        .full         (full),
        .empty        (empty)
    );

    // Record payload is a fixed function of the PC so the head can be checked from the PC alone.
    function automatic logic [31:0] f_inst(logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction
    function automatic logic [31:0] f_wbd(logic [31:0] pc);
        return pc * 32'd3 + 32'd7;
    endfunction

    typedef struct {
        logic        start;
        logic        trig_en;
        logic [31:0] trig_pc;
        logic [15:0] limit;
        logic        cv;
        logic [31:0] pc;
        logic        rdy;
        logic [1:0]  e_state;
        logic [15:0] e_count;
        logic        e_valid;
        logic [31:0] e_head;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic st, logic te, logic [31:0] tpc, logic [15:0] lim,
                                logic cv, logic [31:0] pc, logic rdy,
                                logic [1:0] es, logic [15:0] ec, logic ev, logic [31:0] eh);
        vec_t v;
        v.start = st; v.trig_en = te; v.trig_pc = tpc; v.limit = lim;
        v.cv = cv; v.pc = pc; v.rdy = rdy;
        v.e_state = es; v.e_count = ec; v.e_valid = ev; v.e_head = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        chk({tag, ".pc"},    64'(out_pc), 64'(pc));
        chk({tag, ".inst"},  64'(out_inst), 64'(f_inst(pc)));
        chk({tag, ".wben"},  64'(out_wb_en), 64'(pc[2]));
        chk({tag, ".wba"},   64'(out_wb_addr), 64'(pc[6:2]));
        chk({tag, ".wbd"},   64'(out_wb_data), 64'(f_wbd(pc)));
    endtask

    task automatic drive_cmt(input logic v, input logic [31:0] pc);
        cmt_valid   = v;
        cmt_pc      = pc;
        cmt_inst    = f_inst(pc);
        cmt_wb_en   = pc[2];
        cmt_wb_addr = pc[6:2];
        cmt_wb_data = f_wbd(pc);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    localparam logic [31:0] B0 = 32'h0040_0000;
    localparam logic [31:0] BA = 32'h0040_1000;
    localparam logic [31:0] BB = 32'h0040_2000;
    localparam logic [31:0] BC = 32'h0040_3000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_trig_en = 1'b0; cfg_trig_pc = '0;
        cfg_limit = '0; out_ready = 1'b0;
        drive_cmt(1'b0, 32'h0);
        step();
        step();
        reset = 1'b0;

        chk("rst.state", 64'(state_o), 64'd0);
        chk("rst.count", 64'(count_o), 64'd0);
        chk("rst.ovf",   64'(overflow_cnt), 64'd0);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.full",  64'(full), 64'd0);
        chk("rst.valid", 64'(out_valid), 64'd0);

        // Limit 3 without trigger, then drain.
        vq.push_back(mk(1, 0, 0,          3, 0, 0,         0, 2, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,          0, 1, B0 + 0,    0, 2, 1, 1, B0));
        vq.push_back(mk(0, 0, 0,          0, 1, B0 + 4,    0, 2, 2, 1, B0));
        vq.push_back(mk(0, 0, 0,          0, 1, B0 + 8,    0, 3, 3, 1, B0));
        vq.push_back(mk(0, 0, 0,          0, 1, B0 + 12,   0, 3, 3, 1, B0));
        vq.push_back(mk(0, 0, 0,          0, 1, B0 + 16,   0, 3, 3, 1, B0));
        vq.push_back(mk(0, 0, 0,          0, 0, 0,         1, 3, 3, 1, B0 + 4));
        vq.push_back(mk(0, 0, 0,          0, 0, 0,         1, 3, 3, 1, B0 + 8));
        vq.push_back(mk(0, 0, 0,          0, 0, 0,         1, 3, 3, 0, 0));
        // Trigger at 0x0040000C, unlimited.
        vq.push_back(mk(1, 1, B0 + 12,    0, 0, 0,         0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, B0 + 12,    0, 1, B0 + 0,    0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, B0 + 12,    0, 1, B0 + 4,    0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, B0 + 12,    0, 1, B0 + 8,    0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, B0 + 12,    0, 1, B0 + 12,   0, 2, 1, 1, B0 + 12));
        vq.push_back(mk(0, 0, B0 + 12,    0, 1, B0 + 16,   0, 2, 2, 1, B0 + 12));
        vq.push_back(mk(0, 0, B0 + 12,    0, 1, B0 + 20,   0, 2, 3, 1, B0 + 12));
        // Restart with a same-cycle commit: not captured, FIFO kept.
        vq.push_back(mk(1, 0, B0 + 12,    0, 1, B0 + 24,   0, 2, 0, 1, B0 + 12));
        vq.push_back(mk(0, 0, B0 + 12,    0, 0, 0,         1, 2, 0, 1, B0 + 16));
        vq.push_back(mk(0, 0, B0 + 12,    0, 0, 0,         1, 2, 0, 1, B0 + 20));
        vq.push_back(mk(0, 0, B0 + 12,    0, 0, 0,         1, 2, 0, 0, 0));
        // Limit 1 with trigger: trigger commit captured, then DONE.
        vq.push_back(mk(1, 1, B0 + 256,   1, 0, 0,         0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, B0 + 256,   0, 1, B0 + 256,  0, 3, 1, 1, B0 + 256));
        vq.push_back(mk(0, 0, B0 + 256,   0, 1, B0 + 256,  1, 3, 1, 0, 0));

        foreach (vq[i]) begin
            cfg_start   = vq[i].start;
            cfg_trig_en = vq[i].trig_en;
            cfg_trig_pc = vq[i].trig_pc;
            cfg_limit   = vq[i].limit;
            out_ready   = vq[i].rdy;
            drive_cmt(vq[i].cv, vq[i].pc);
            step();
            chk($sformatf("v%0d.state", i), 64'(state_o), 64'(vq[i].e_state));
            chk($sformatf("v%0d.count", i), 64'(count_o), 64'(vq[i].e_count));
            chk($sformatf("v%0d.valid", i), 64'(out_valid), 64'(vq[i].e_valid));
            if (vq[i].e_valid) check_head($sformatf("v%0d", i), vq[i].e_head);
        end
        cfg_start = 1'b0; out_ready = 1'b0;
        drive_cmt(1'b0, 32'h0);

        // Overflow: 20 commits into a 16-entry FIFO with the consumer stalled.
        reset = 1'b1; step(); reset = 1'b0;
        cfg_start = 1'b1; cfg_trig_en = 1'b0; cfg_limit = '0; step(); cfg_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive_cmt(1'b1, BA + 32'(4 * k));
            step();
            if (k == 14) chk("ovf.full_at15", 64'(full), 64'd0);
            if (k == 15) chk("ovf.full_at16", 64'(full), 64'd1);
        end
        chk("ovf.count20", 64'(count_o), 64'd20);
        chk("ovf.cnt4",    64'(overflow_cnt), 64'd4);
        chk("ovf.full",    64'(full), 64'd1);
        check_head("ovf.head", BA);

        // Full with a pop and a push together: push dropped, pop taken.
        out_ready = 1'b1;
        drive_cmt(1'b1, BA + 32'd80);
        step();
        chk("fp.ovf5",   64'(overflow_cnt), 64'd5);
        chk("fp.count",  64'(count_o), 64'd21);
        chk("fp.full",   64'(full), 64'd0);
        chk("fp.empty",  64'(empty), 64'd0);
        check_head("fp.head", BA + 32'd4);

        drive_cmt(1'b0, 32'h0);
        begin
            int got = 0;
            for (int c = 0; c < 40 && out_valid; c++) begin
                check_head($sformatf("drain%0d", got), BA + 32'(4 * (1 + got)));
                got++;
                step();
            end
            chk("drain.n", 64'(got), 64'd15);
        end

        // Zero-bubble streaming with the consumer always ready.
        begin
`ifdef TRACE_CYCLE_STAMP_EN
            logic [31:0] prev_stamp = '0;
`endif
            for (int k = 0; k < 10; k++) begin
                drive_cmt(1'b1, BB + 32'(4 * k));
                step();
                chk($sformatf("str%0d.valid", k), 64'(out_valid), 64'd1);
                check_head($sformatf("str%0d", k), BB + 32'(4 * k));
`ifdef TRACE_CYCLE_STAMP_EN
                if (k > 0) chk($sformatf("str%0d.stamp", k), 64'(out_cycle - prev_stamp), 64'd1);
                prev_stamp = out_cycle;
`endif
            end
        end
        chk("str.ovf",   64'(overflow_cnt), 64'd5);
        chk("str.count", 64'(count_o), 64'd31);
        drive_cmt(1'b0, 32'h0);
        step();
        chk("str.end_valid", 64'(out_valid), 64'd0);
        chk("str.end_empty", 64'(empty), 64'd1);

        // Reset mid-capture with 5 records buffered.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_cmt(1'b1, BC + 32'(4 * k));
            step();
        end
        chk("mid.count", 64'(count_o), 64'd36);
        check_head("mid.head", BC);
        reset = 1'b1;
        drive_cmt(1'b1, BC + 32'd20);
        step();
        reset = 1'b0;
        chk("mr.empty", 64'(empty), 64'd1);
        chk("mr.valid", 64'(out_valid), 64'd0);
        chk("mr.state", 64'(state_o), 64'd0);
        chk("mr.count", 64'(count_o), 64'd0);
        chk("mr.ovf",   64'(overflow_cnt), 64'd0);
        chk("mr.full",  64'(full), 64'd0);
        step();
        chk("idle.nocap", 64'(empty), 64'd1);
        drive_cmt(1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable, parametrised commit-trace capture unit for the single-cycle MIPS SoC.
- Records retired instructions into an internal FIFO: PC, instruction word, and register write-back (enable, address, data).
- Supports trigger-on-PC start, a bounded capture window and overflow accounting.
- A valid/ready stream drains the FIFO to a host or bench. This replaces ad-hoc per-cycle register dumps with an on-chip trace buffer.

Parameters:
- PC_W, 32, width of the PC, instruction and write-back data fields.
- REG_AW, 5, register-file address width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the limit, count and overflow counters.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clk_in cycle asserted fully clears the block.
- cfg_start  in  1  one-cycle pulse; begins (or restarts) a capture session.
- cfg_trig_en  in  1  1 = wait for cfg_trig_pc before capturing; sampled on cfg_start.
- cfg_trig_pc  in  PC_W  trigger PC; used while ARMED.
- cfg_limit  in  CNT_W  commits per session, 0 = unlimited; sampled on cfg_start.
- cmt_valid  in  1  one instruction retires this cycle.
- cmt_pc  in  PC_W  PC of the retiring instruction.
- cmt_inst  in  PC_W  instruction word.
- cmt_wb_en  in  1  register write-back enable.
- cmt_wb_addr  in  REG_AW  destination register.
- cmt_wb_data  in  PC_W  write-back value.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_pc, out_inst  out  PC_W each  head record fields.
- out_wb_en  out  1  head record field.
- out_wb_addr  out  REG_AW  head record field.
- out_wb_data  out  PC_W  head record field.
- state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- count_o  out  CNT_W  commits seen in CAPTURE this session.
- overflow_cnt  out  CNT_W  commits dropped because the FIFO was full; saturating.
- full, empty  out  1 each  FIFO status.

Behaviour:
- Reset values:
  - state IDLE, count_o 0, overflow_cnt 0.
  - FIFO pointers 0, so empty=1, full=0, out_valid=0.
  - Latched limit and trigger-enable cleared to 0.
  - out_* data fields are don't-care while out_valid=0.
- FIFO:
  - Register array, read/write pointers of log2(DEPTH)+1 bits; wrap via the extra MSB.
  - full/empty are derived from the registered pointers.
  - out_* is a combinational read of the head entry; out_valid = !empty.
  - Pop occurs when out_valid && out_ready.
- Capture event: cmt_valid && (state==CAPTURE || (state==ARMED && cmt_pc==cfg_trig_pc)).
  - Push if !full; otherwise drop and increment overflow_cnt, holding at all-ones.
  - full is evaluated before this cycle's pop: a push at full with a simultaneous pop is dropped, and the pop still occurs.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave occupancy unchanged.
  - Latency: a record captured at edge N gives out_valid=1 from edge N onward when the FIFO was empty; zero-bubble streaming.
- count_o increments on every capture event, pushed or dropped.
- FSM:
  - IDLE: on cfg_start → ARMED if cfg_trig_en, else → CAPTURE.
  - ARMED: on a commit with cmt_pc==cfg_trig_pc → CAPTURE. The triggering commit is itself captured and counted.
  - CAPTURE: when a capture event makes count_o equal the nonzero latched limit → DONE that edge. The limit-reaching commit is captured.
  - DONE: no capture; the FIFO keeps draining.
  - cfg_start in any state restarts the session:
    - latches limit and trigger-enable, clears count_o, and enters ARMED or CAPTURE;
    - does not flush FIFO contents or clear overflow_cnt;
    - a commit in the same cycle as cfg_start is not captured.
- Limit behaviour:
  - limit=0: CAPTURE runs until the next cfg_start or reset.
  - count_o saturates at all-ones.
  - limit=1 with trigger enabled: the trigger commit is captured, then → DONE.
- reset asserted mid-session or mid-drain: everything returns to reset values on that edge; the FIFO is emptied.

Optional Feature:
- Macro TRACE_CYCLE_STAMP_EN.
- When defined:
  - adds a free-running 32-bit cycle counter, cleared by reset and wrapping at 2^32;
  - each record stores the counter value at its capture edge;
  - an extra output out_cycle (32 bits) presents the head record's stamp.
- When undefined: no counter, no out_cycle port, and no extra storage.

Test Plan:
- Reset, cfg_start with trig_en=0, limit=3, five consecutive commits at pc 0x00400000+4k → count_o=3, state DONE after the third, exactly 3 records drained in order with matching pc/inst/wb fields.
- trig_en=1, trig_pc=0x0040000C, commits at 0x..00–0x..14 → ARMED until 0x..0C; first record pc=0x0040000C; commit at 0x..10 also captured (limit 0).
- DEPTH=16, out_ready=0, 20 commits in CAPTURE → full=1 after 16, overflow_cnt=4, count_o=20; then out_ready=1 drains exactly 16 records, the first 16 in order.
- FIFO full and out_ready=1 with a commit in the same cycle → commit dropped (overflow_cnt+1), one pop, occupancy 15.
- Steady streaming with out_ready=1 and a commit every cycle → out_valid continuously 1, each record appears one cycle after capture, no drops.
- reset pulse mid-CAPTURE with 5 records buffered → next cycle: empty=1, out_valid=0, state IDLE, count_o=0, overflow_cnt=0. With TRACE_CYCLE_STAMP_EN, stamps of back-to-back records differ by 1.
